pc_bank: RTL

PC_BANK -- requirements
Module: pc_bank

---
 rtl/pc_bank_pkg.sv | 12 +
 rtl/pc_chan.sv | 105 ++++++++++
 rtl/pc_bank.sv | 54 +++++
 3 files changed

// File: rtl/pc_bank_pkg.sv
// Shared types and constants for the pc_bank program-counter block.
package pc_bank_pkg;

  localparam int DELAY_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DELAY = 2'd1,
    HALT  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/pc_chan.sv
// One program-counter channel: next-PC selection, wrap, delay hold and
// optional breakpoint halt (enabled by defining PC_BKPT_EN).
module pc_chan
  import pc_bank_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               penable,
  input  logic               restart,
  input  logic               imm,
  input  logic               jmp,
  input  logic [ADDR_W-1:0]  din,
  input  logic [ADDR_W-1:0]  pend,
  input  logic [ADDR_W-1:0]  wrap_target,
  input  logic               stalled,
  input  logic [DELAY_W-1:0] delay,
`ifdef PC_BKPT_EN
  input  logic               bkpt_en,
  input  logic [ADDR_W-1:0]  bkpt_addr,
  output logic               halted,
`endif
  output logic [ADDR_W-1:0]  dout,
  output logic [ADDR_W-1:0]  pc,
  output logic               delaying
);

  chan_state_e        state, state_nxt;
  logic [DELAY_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0]  adv;

  // Sequential advance target; pc + 1 rolls over modulo 2^ADDR_W.
  always_comb begin
    adv = pc + 1'b1;
    if (jmp)              adv = din;
    else if (pc == pend)  adv = wrap_target;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    cnt_nxt   = cnt;
    dout      = pc;
    if (restart) begin
      dout      = '0;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (imm) begin
      if (jmp) dout = din;
      state_nxt = RUN;
      cnt_nxt   = '0;
`ifdef PC_BKPT_EN
      if (state == HALT && !jmp) state_nxt = HALT;
`endif
    end else begin
      unique case (state)
        RUN: begin
          if (penable && !stalled) begin
            dout = adv;
            if (delay != '0) begin
              cnt_nxt   = delay;
              state_nxt = DELAY;
            end
`ifdef PC_BKPT_EN
            if (bkpt_en && adv == bkpt_addr) begin
              cnt_nxt   = '0;
              state_nxt = HALT;
            end
`endif
          end
        end
        DELAY: begin
          if (penable) begin
            cnt_nxt = cnt - 1'b1;
            if (cnt <= DELAY_W'(1)) begin
              cnt_nxt   = '0;
              state_nxt = RUN;
            end
          end
        end
        default: ;  // HALT holds until restart or imm+jmp
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= '0;
      cnt   <= '0;
      state <= RUN;
    end else begin
      pc    <= dout;
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  assign delaying = (state == DELAY);
`ifdef PC_BKPT_EN
  assign halted   = (state == HALT);
`endif

endmodule

// File: rtl/pc_bank.sv
// Bank of NUM_SM independent program counters, one pc_chan per channel.
// Breakpoint ports and HALT behaviour are present only with PC_BKPT_EN defined.
module pc_bank
  import pc_bank_pkg::*;
#(
  parameter int NUM_SM = 4,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SM-1:0]         penable,
  input  logic [NUM_SM-1:0]         restart,
  input  logic [NUM_SM-1:0]         imm,
  input  logic [NUM_SM-1:0]         jmp,
  input  logic [NUM_SM*ADDR_W-1:0]  din,
  input  logic [NUM_SM*ADDR_W-1:0]  pend,
  input  logic [NUM_SM*ADDR_W-1:0]  wrap_target,
  input  logic [NUM_SM-1:0]         stalled,
  input  logic [NUM_SM*DELAY_W-1:0] delay,
`ifdef PC_BKPT_EN
  input  logic [NUM_SM-1:0]         bkpt_en,
  input  logic [NUM_SM*ADDR_W-1:0]  bkpt_addr,
  output logic [NUM_SM-1:0]         halted,
`endif
  output logic [NUM_SM*ADDR_W-1:0]  dout,
  output logic [NUM_SM*ADDR_W-1:0]  pc,
  output logic [NUM_SM-1:0]         delaying
);

  for (genvar g = 0; g < NUM_SM; g++) begin : g_chan
    pc_chan #(.ADDR_W(ADDR_W)) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .penable     (penable[g]),
      .restart     (restart[g]),
      .imm         (imm[g]),
      .jmp         (jmp[g]),
      .din         (din[g*ADDR_W +: ADDR_W]),
      .pend        (pend[g*ADDR_W +: ADDR_W]),
      .wrap_target (wrap_target[g*ADDR_W +: ADDR_W]),
      .stalled     (stalled[g]),
      .delay       (delay[g*DELAY_W +: DELAY_W]),
`ifdef PC_BKPT_EN
      .bkpt_en     (bkpt_en[g]),
      .bkpt_addr   (bkpt_addr[g*ADDR_W +: ADDR_W]),
      .halted      (halted[g]),
`endif
      .dout        (dout[g*ADDR_W +: ADDR_W]),
      .pc          (pc[g*ADDR_W +: ADDR_W]),
      .delaying    (delaying[g])
    );
  end

endmodule
